// File: rtl/arb_pkg.sv
// arb_pkg: shared arbiter types, defaults and the round-robin search helper.
package arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_e;

    localparam int ARB_N_REQ_DEF = 2;
    localparam int ARB_MAX_REQ   = 8;

    // Index of the first set bit of req at or after ptr, wrapping modulo n.
    // Returns ptr when req is empty; callers qualify with their own found flag.
    function automatic logic [2:0] rr_first(input logic [ARB_MAX_REQ-1:0] req,
                                            input logic [2:0] ptr, input int n);
        logic [2:0] idx;
        logic       hit;
        int         j;
        idx = ptr;
        hit = 1'b0;
        for (int k = 0; k < ARB_MAX_REQ; k++) begin
            j = (int'(ptr) + k) % n;
            if (k < n && !hit && req[j]) begin
                idx = 3'(j);
                hit = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational one-hot pick of the first request at or after ptr.
module rr_priority_picker
    import arb_pkg::*;
#(
    parameter  int N_REQ = ARB_N_REQ_DEF,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] pick,
    output logic             found
);

    logic [ARB_MAX_REQ-1:0] req_w;
    logic [2:0]             idx;

    // Widen to the helper's fixed width, search with wrap, then decode one-hot.
    always_comb begin
        req_w            = '0;
        req_w[N_REQ-1:0] = req;
        idx              = rr_first(req_w, 3'(ptr), N_REQ);
        found            = |req;
        pick             = found ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with registered one-hot grant held until release.
// Optional macro ARB_HOLD_LIMIT_EN: preempt an owner after MAX_HOLD contended cycles.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter  int N_REQ    = ARB_N_REQ_DEF,
    parameter  int MAX_HOLD = 8,
    localparam int IW       = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] request,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [IW-1:0]    grant_id
);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    owner, nxt, search_ptr;
    logic [N_REQ-1:0] pick;
    logic             found, own_req, others, rotate;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int CW = $clog2(MAX_HOLD) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Owner index, its successor, and whether anyone else is contending.
    always_comb begin
        owner = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grant_q[i]) owner = IW'(i);
        nxt        = IW'((int'(owner) + 1) % N_REQ);
        search_ptr = (state_q == BUSY) ? nxt : ptr_q;
        own_req    = |(request & grant_q);
        others     = |(request & ~grant_q);
    end

    // The owner is masked out so a preemption never re-picks it; on a release its bit is already low.
    rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
        .req   (request & ~grant_q),
        .ptr   (search_ptr),
        .pick  (pick),
        .found (found)
    );

`ifdef ARB_HOLD_LIMIT_EN
    assign rotate = others && (cnt_q == CW'(MAX_HOLD - 1));
`else
    assign rotate = 1'b0;
`endif

    // Next-state: grant from idle, hand off (or go idle) on release, rotate on hold limit.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        if (state_q == IDLE) begin
            if (found) begin
                grant_d = pick;
                state_d = BUSY;
            end
        end else if (!own_req || rotate) begin
            ptr_d   = nxt;
            grant_d = pick;
            state_d = found ? BUSY : IDLE;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    // Hold counter: counts contended busy cycles, cleared whenever the grant changes.
    always_comb begin
        cnt_d = (grant_d != grant_q) ? '0 :
                (state_q == BUSY && others) ? cnt_q + CW'(1) : cnt_q;
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_id    = owner;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed and randomized checks of rr_arbiter against a behavioural model.
module tb_rr_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 8;
    localparam int IW   = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  request = '0;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_id;

    int n_tests = 0;
    int n_fail  = 0;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;

    rr_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .request     (request),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int search(input logic [N-1:0] r, input int from);
        for (int k = 0; k < N; k++)
            if (r[(from + k) % N]) return (from + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_grant();
        return (m_owner < 0) ? '0 : (N'(1) << m_owner);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        logic [N-1:0] oth;
        if (m_owner < 0) begin
            m_owner = search(r, m_ptr);
        end else if (!r[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = search(r, m_ptr);
            m_hold  = 0;
        end else begin
            oth = r;
            oth[m_owner] = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
            if (oth != 0) begin
                if (m_hold == MAXH - 1) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = search(oth, m_ptr);
                    m_hold  = 0;
                end else begin
                    m_hold++;
                end
            end
`endif
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".grant"}, 32'(grant), 32'(exp_grant()));
        chk({tag, ".valid"}, 32'(grant_valid), 32'(m_owner >= 0));
        chk({tag, ".id"}, 32'(grant_id), 32'((m_owner < 0) ? 0 : m_owner));
    endtask

    task automatic cycle(input logic [N-1:0] r, input string tag);
        request = r;
        @(posedge clk);
        if (rst_n) model_step(r);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst.grant", 32'(grant), 0);
        chk("rst.valid", 32'(grant_valid), 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst.hold", 32'(grant), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] r;
        @(negedge clk);
        // Reset with requests held; first grant one edge after release goes to requester 0.
        request = 4'b0011;
        do_reset();
        cycle(4'b0011, "t1");
        chk("t1.first", 32'(grant), 32'h1);
        chk("t1.id", 32'(grant_id), 0);
        // Zero-bubble handoff, then idle.
        cycle(4'b0010, "t2a");
        chk("t2.handoff", 32'(grant), 32'h2);
        cycle(4'b0000, "t2b");
        chk("t2.idle", 32'(grant), 0);
        chk("t2.valid", 32'(grant_valid), 0);
        // Fairness: owner drops for a cycle and re-raises; the other side always wins next.
        do_reset();
        cycle(4'b0011, "t3");
        chk("t3.start", 32'(grant), 32'h1);
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0010, "t3a");
            chk("t3.to1", 32'(grant), 32'h2);
            cycle(4'b0011, "t3b");
            chk("t3.keep1", 32'(grant), 32'h2);
            cycle(4'b0001, "t3c");
            chk("t3.to0", 32'(grant), 32'h1);
            cycle(4'b0011, "t3d");
            chk("t3.keep0", 32'(grant), 32'h1);
        end
        // Asynchronous reset mid-grant clears outputs immediately; pointer restarts at 0.
        do_reset();
        cycle(4'b0010, "t4");
        chk("t4.pre", 32'(grant), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t4.async", 32'(grant), 0);
        chk("t4.async_id", 32'(grant_id), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'b0011, "t4b");
        chk("t4.restart", 32'(grant), 32'h1);
        // Owner 3 holds against a waiting requester 0.
        do_reset();
        cycle(4'b1000, "t5");
        chk("t5.own3", 32'(grant), 32'h8);
        for (int i = 0; i < 22; i++) begin
            cycle(4'b1001, "t5h");
`ifdef ARB_HOLD_LIMIT_EN
            if (i < 7) chk("t5.hold", 32'(grant), 32'h8);
            else if (i < 15) chk("t5.rot", 32'(grant), 32'h1);
`else
            chk("t5.hold", 32'(grant), 32'h8);
`endif
        end
        // A one-cycle pulse while busy is lost.
        do_reset();
        cycle(4'b0001, "t6");
        cycle(4'b0011, "t6p");
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0001, "t6w");
            chk("t6.nogrant1", 32'(grant[1]), 0);
        end
        cycle(4'b0000, "t6e");
        chk("t6.idle", 32'(grant), 0);
        // Randomized sticky requests with occasional asynchronous resets.
        do_reset();
        r = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                chk("rnd.async", 32'(grant), 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            if (i % 300 < 150) r ^= N'($urandom) & N'($urandom);
            else r ^= N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom);
            cycle(r, "rnd");
            chk("rnd.onehot", 32'($countones(grant) <= 1), 1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
